// File: rtl/gpu_cache_fill_arbiter_if.sv
// Fill-arbiter bus: fill requests and completes from the pixel pipeline, the
// shared VRAM burst-read port, and the indexed cache-line write port.
interface gpu_cache_fill_arbiter_if;
  // Pixel pipeline requests and completion pulses
  logic        i_texFillReq;
  logic [16:0] i_texFillAdr;
  logic        o_texFillComplete;
  logic        i_clutFillReq;
  logic [14:0] i_clutFillAdr;
  logic        o_clutFillComplete;

  // Shared VRAM burst-read port
  logic        o_memReq;
  logic [17:0] o_memAdr;
  logic [3:0]  o_memBurstLen;
  logic        i_memAck;
  logic        i_memDataValid;
  logic [31:0] i_memData;

  // Cache-line write port
  logic        o_texWrite;
  logic        o_texWriteBeat;
  logic        o_clutWrite;
  logic [2:0]  o_clutWriteBeat;
  logic [31:0] o_writeData;
  logic        o_busy;

  // Arbiter side
  modport slave (
    input  i_texFillReq, i_texFillAdr, i_clutFillReq, i_clutFillAdr,
           i_memAck, i_memDataValid, i_memData,
    output o_texFillComplete, o_clutFillComplete,
           o_memReq, o_memAdr, o_memBurstLen,
           o_texWrite, o_texWriteBeat, o_clutWrite, o_clutWriteBeat,
           o_writeData, o_busy
  );

  // Pipeline, memory and cache side
  modport master (
    output i_texFillReq, i_texFillAdr, i_clutFillReq, i_clutFillAdr,
           i_memAck, i_memDataValid, i_memData,
    input  o_texFillComplete, o_clutFillComplete,
           o_memReq, o_memAdr, o_memBurstLen,
           o_texWrite, o_texWriteBeat, o_clutWrite, o_clutWriteBeat,
           o_writeData, o_busy
  );
endinterface

// File: rtl/gpu_cache_fill_arbiter.sv
// Round-robin Tex$/CLUT$ line-fill sequencer over one shared VRAM burst port.
// Returned beats become indexed cache writes; the last one carries the complete pulse.
module gpu_cache_fill_arbiter #(
  parameter int TEX_BEATS  = 2,
  parameter int CLUT_BEATS = 8
) (
  input  logic clk,
  input  logic i_nrst,
  gpu_cache_fill_arbiter_if.slave bus
);

  localparam logic [3:0] TEX_LEN  = 4'(TEX_BEATS);
  localparam logic [3:0] CLUT_LEN = 4'(CLUT_BEATS);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;
  typedef enum logic {OWN_TEX, OWN_CLUT} owner_e;

  typedef struct packed {
    owner_e      owner;
    logic [17:0] adr;
    logic [3:0]  len;
  } fill_t;

  state_e      state_q, state_d;
  fill_t       fill_q, fill_d;
  owner_e      last_q, last_d;
  logic [3:0]  beat_q, beat_d;
  logic        memReq_q, memReq_d;
  logic        texWr_q, texWr_d;
  logic        clutWr_q, clutWr_d;
  logic [2:0]  wrBeat_q, wrBeat_d;
  logic [31:0] wrData_q, wrData_d;
  logic        texCmp_q, texCmp_d;
  logic        clutCmp_q, clutCmp_d;
  logic        busy_q, busy_d;
  logic        grant_clut;
  logic        last_beat;

  // On a tie the owner not granted last time wins
  assign grant_clut = bus.i_clutFillReq && (!bus.i_texFillReq || last_q == OWN_TEX);
  assign last_beat  = (beat_q == fill_q.len - 4'd1);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    last_d    = last_q;
    beat_d    = beat_q;
    wrBeat_d  = wrBeat_q;
    wrData_d  = wrData_q;
    texWr_d   = 1'b0;
    clutWr_d  = 1'b0;
    texCmp_d  = 1'b0;
    clutCmp_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_texFillReq || bus.i_clutFillReq) begin
          state_d = REQ;
          beat_d  = 4'd0;
          if (grant_clut) begin
            fill_d.owner = OWN_CLUT;
            fill_d.adr   = {bus.i_clutFillAdr, 3'b000};
            fill_d.len   = CLUT_LEN;
            last_d       = OWN_CLUT;
          end else begin
            fill_d.owner = OWN_TEX;
            fill_d.adr   = {bus.i_texFillAdr, 1'b0};
            fill_d.len   = TEX_LEN;
            last_d       = OWN_TEX;
          end
        end
      end
      REQ: begin
        if (bus.i_memAck) state_d = DATA;
      end
      DATA: begin
        if (bus.i_memDataValid) begin
          wrBeat_d = beat_q[2:0];
          wrData_d = bus.i_memData;
          texWr_d  = (fill_q.owner == OWN_TEX);
          clutWr_d = (fill_q.owner == OWN_CLUT);
          beat_d   = beat_q + 4'd1;
          // Complete rides with the final write so the cache sees a full line
          if (last_beat) begin
            state_d   = DONE;
            texCmp_d  = (fill_q.owner == OWN_TEX);
            clutCmp_d = (fill_q.owner == OWN_CLUT);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    memReq_d = (state_d == REQ);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      last_q    <= OWN_TEX;
      beat_q    <= 4'd0;
      memReq_q  <= 1'b0;
      texWr_q   <= 1'b0;
      clutWr_q  <= 1'b0;
      wrBeat_q  <= 3'd0;
      wrData_q  <= 32'd0;
      texCmp_q  <= 1'b0;
      clutCmp_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      memReq_q  <= memReq_d;
      texWr_q   <= texWr_d;
      clutWr_q  <= clutWr_d;
      wrBeat_q  <= wrBeat_d;
      wrData_q  <= wrData_d;
      texCmp_q  <= texCmp_d;
      clutCmp_q <= clutCmp_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_memReq           = memReq_q;
  assign bus.o_memAdr           = fill_q.adr;
  assign bus.o_memBurstLen      = fill_q.len;
  assign bus.o_texWrite         = texWr_q;
  assign bus.o_texWriteBeat     = wrBeat_q[0];
  assign bus.o_clutWrite        = clutWr_q;
  assign bus.o_clutWriteBeat    = wrBeat_q;
  assign bus.o_writeData        = wrData_q;
  assign bus.o_texFillComplete  = texCmp_q;
  assign bus.o_clutFillComplete = clutCmp_q;
  assign bus.o_busy             = busy_q;

endmodule

// File: tb/tb_gpu_cache_fill_arbiter.sv
// Randomized bench for gpu_cache_fill_arbiter: a transaction-level model picks the
// owner and expected address per fill; a memory responder feeds random beats.
module tb_gpu_cache_fill_arbiter;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  gpu_cache_fill_arbiter_if bus();

  gpu_cache_fill_arbiter #(.TEX_BEATS(2), .CLUT_BEATS(8)) dut (
    .clk(clk),
    .i_nrst(nrst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit last_clut;  // model: owner of the previous grant (0 = tex)

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_texFillReq   = 1'b0;
    bus.i_texFillAdr   = '0;
    bus.i_clutFillReq  = 1'b0;
    bus.i_clutFillAdr  = '0;
    bus.i_memAck       = 1'b0;
    bus.i_memDataValid = 1'b0;
    bus.i_memData      = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wr/cmp"}, 32'({bus.o_texWrite, bus.o_clutWrite,
                              bus.o_texFillComplete, bus.o_clutFillComplete}), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " memReq/busy"}, 32'({bus.o_memReq, bus.o_busy}), 32'd0);
    chk({tag, " memAdr"}, 32'(bus.o_memAdr), 32'd0);
    chk({tag, " burstLen"}, 32'(bus.o_memBurstLen), 32'd0);
    chk_quiet(tag);
    chk({tag, " beats"}, 32'({bus.o_texWriteBeat, bus.o_clutWriteBeat}), 32'd0);
    chk({tag, " wdata"}, bus.o_writeData, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    nrst = 1'b0;
    #1;
    chk_zero(tag);
    tick();
    tick();
    nrst = 1'b1;
    last_clut = 1'b0;
  endtask

  // Caller sets requests/addresses for the next edge while the DUT is idle.
  task automatic run_fill(input string tag, input int ack_min, input int ack_max,
                          input int max_gap, input int drop_after, input int rst_after,
                          input bit fixed_data);
    bit          own_clut;
    logic [17:0] eadr;
    int          n;
    int          k;
    logic [31:0] d;

    own_clut  = bus.i_clutFillReq && (!bus.i_texFillReq || !last_clut);
    eadr      = own_clut ? 18'(bus.i_clutFillAdr * 8) : 18'(bus.i_texFillAdr * 2);
    n         = own_clut ? 8 : 2;
    last_clut = own_clut;

    tick();
    chk({tag, " memReq"}, 32'(bus.o_memReq), 32'd1);
    chk({tag, " memAdr"}, 32'(bus.o_memAdr), 32'(eadr));
    chk({tag, " burstLen"}, 32'(bus.o_memBurstLen), 32'(n));
    chk({tag, " busy"}, 32'(bus.o_busy), 32'd1);

    // Ack stall: stray beats and input address churn must not matter
    k = $urandom_range(ack_max, ack_min);
    for (int i = 0; i < k; i++) begin
      bus.i_memAck       = 1'b0;
      bus.i_memDataValid = 1'($urandom_range(1, 0));
      bus.i_memData      = $urandom;
      bus.i_texFillAdr   = 17'($urandom);
      bus.i_clutFillAdr  = 15'($urandom);
      tick();
      chk({tag, " wait memReq"}, 32'(bus.o_memReq), 32'd1);
      chk({tag, " wait memAdr"}, 32'(bus.o_memAdr), 32'(eadr));
      chk_quiet({tag, " wait"});
    end
    bus.i_memDataValid = 1'b0;
    bus.i_memAck       = 1'b1;
    tick();
    bus.i_memAck = 1'b0;
    chk({tag, " ack memReq"}, 32'(bus.o_memReq), 32'd0);
    chk_quiet({tag, " ack"});

    for (int b = 0; b < n; b++) begin
      k = $urandom_range(max_gap, 0);
      for (int i = 0; i < k; i++) begin
        tick();
        chk_quiet({tag, " gap"});
        chk({tag, " gap busy"}, 32'(bus.o_busy), 32'd1);
      end
      d = fixed_data ? 32'h11111111 * 32'(b + 1) : $urandom;
      bus.i_memDataValid = 1'b1;
      bus.i_memData      = d;
      tick();
      bus.i_memDataValid = 1'b0;
      bus.i_memData      = $urandom;
      chk({tag, " strobes"}, 32'({bus.o_texWrite, bus.o_clutWrite}), own_clut ? 32'd1 : 32'd2);
      chk({tag, " beat"}, own_clut ? 32'(bus.o_clutWriteBeat) : 32'(bus.o_texWriteBeat), 32'(b));
      chk({tag, " wdata"}, bus.o_writeData, d);
      chk({tag, " complete"}, 32'({bus.o_texFillComplete, bus.o_clutFillComplete}),
          (b != n - 1) ? 32'd0 : (own_clut ? 32'd1 : 32'd2));
      if (b == drop_after) begin
        if (own_clut) bus.i_clutFillReq = 1'b0;
        else          bus.i_texFillReq  = 1'b0;
      end
      if (b == rst_after) begin
        bus.i_texFillReq  = 1'b0;
        bus.i_clutFillReq = 1'b0;
        nrst = 1'b0;
        #1;
        chk_zero({tag, " rst"});
        for (int i = 0; i < 5; i++) begin
          bus.i_memDataValid = 1'b1;
          bus.i_memData      = $urandom;
          if (i == 2) nrst = 1'b1;
          tick();
          chk_quiet({tag, " post-rst"});
          chk({tag, " post-rst busy"}, 32'(bus.o_busy), 32'd0);
        end
        bus.i_memDataValid = 1'b0;
        last_clut = 1'b0;
        return;
      end
    end

    // DONE cycle: requester drops its request on this edge
    chk({tag, " done busy"}, 32'(bus.o_busy), 32'd1);
    if (own_clut) bus.i_clutFillReq = 1'b0;
    else          bus.i_texFillReq  = 1'b0;
    tick();
    chk({tag, " idle busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, " idle memReq"}, 32'(bus.o_memReq), 32'd0);
    chk_quiet({tag, " idle"});
  endtask

  initial begin
    clear_inputs();
    nrst = 1'b0;
    #3;
    do_reset("reset");

    // Tex fill, immediate ack, back-to-back beats
    bus.i_texFillReq = 1'b1;
    bus.i_texFillAdr = 17'h1ABCD;
    run_fill("t1 tex", 0, 0, 0, -1, -1, 1'b1);

    // CLUT fill at top address with gaps
    bus.i_clutFillReq = 1'b1;
    bus.i_clutFillAdr = 15'h7FFF;
    run_fill("t2 clut", 0, 2, 3, -1, -1, 1'b0);

    // Stray beats in IDLE, then a long ack stall
    for (int i = 0; i < 4; i++) begin
      bus.i_memDataValid = 1'b1;
      bus.i_memData      = $urandom;
      tick();
      chk_quiet("t4 idle stray");
      chk("t4 idle busy", 32'(bus.o_busy), 32'd0);
    end
    bus.i_memDataValid = 1'b0;
    bus.i_texFillReq   = 1'b1;
    bus.i_texFillAdr   = 17'($urandom);
    run_fill("t4 stall", 20, 20, 1, -1, -1, 1'b0);

    // Tie from reset: CLUT, then tie again favours tex, then CLUT
    do_reset("t3 reset");
    bus.i_texFillReq  = 1'b1;
    bus.i_texFillAdr  = 17'($urandom);
    bus.i_clutFillReq = 1'b1;
    bus.i_clutFillAdr = 15'($urandom);
    run_fill("t3 first", 0, 2, 2, -1, -1, 1'b0);
    bus.i_clutFillReq = 1'b1;
    run_fill("t3 second", 0, 2, 2, -1, -1, 1'b0);
    run_fill("t3 third", 0, 2, 2, -1, -1, 1'b0);

    // Reset mid CLUT burst, then a normal tex fill
    bus.i_clutFillReq = 1'b1;
    bus.i_clutFillAdr = 15'($urandom);
    run_fill("t5 abort", 0, 1, 1, -1, 3, 1'b0);
    bus.i_texFillReq = 1'b1;
    bus.i_texFillAdr = 17'($urandom);
    run_fill("t5 tex", 0, 1, 1, -1, -1, 1'b0);

    // Tex request dropped during DATA
    bus.i_texFillReq = 1'b1;
    bus.i_texFillAdr = 17'($urandom);
    run_fill("t6 drop", 0, 1, 2, 0, -1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6 stay idle", 32'({bus.o_busy, bus.o_memReq}), 32'd0);
    end

    // Random traffic with held requests
    for (int it = 0; it < 30; it++) begin
      if (!bus.i_texFillReq && $urandom_range(1, 0) == 1) begin
        bus.i_texFillReq = 1'b1;
        bus.i_texFillAdr = 17'($urandom);
      end
      if (!bus.i_clutFillReq && $urandom_range(1, 0) == 1) begin
        bus.i_clutFillReq = 1'b1;
        bus.i_clutFillAdr = 15'($urandom);
      end
      if (!bus.i_texFillReq && !bus.i_clutFillReq) begin
        bus.i_texFillReq = 1'b1;
        bus.i_texFillAdr = 17'($urandom);
      end
      run_fill("rand", 0, 3, 2, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
